// File: rtl/bch_decode_sequencer.sv
// bch_decode_sequencer
//   Multi-cycle BCH(15,7,2) decoder controller over GF(16) (x^4+x+1).
//   Syndromes S1/S3 are built bit-serially (Horner, MSB first). The error
//   locator is solved in one cycle. A one-position-per-cycle Chien search
//   then flips the bits it finds in error.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. Each producer holds valid and data until that edge. The
//   block raises cw_ready only in IDLE and msg_valid only in DONE. Result
//   outputs are held stable while msg_valid=1 and msg_ready=0.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cw_valid/cw_ready  input word handshake; cw_data[14:0] holds x^i at bit i
//   msg_valid/msg_ready result handshake
//   msg_data[6:0]      corrected message (raw bits when uncorrectable)
//   err_cnt[1:0]       number of bits corrected
//   uncorrectable      decoding failure flag
//   busy               high in every state except IDLE
module bch_decode_sequencer #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cw_valid,
  output logic        cw_ready,
  input  logic [14:0] cw_data,
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic [6:0]  msg_data,
  output logic [1:0]  err_cnt,
  output logic        uncorrectable,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SYND, LOCATE, SEARCH, DONE} state_t;

  state_t      state;
  logic [14:0] word_r;
  logic [6:0]  orig_r;     // untouched message bits, returned on failure
  logic [3:0]  s1, s3, t1, t2;
  logic [3:0]  cnt;        // bit index in SYND, search position in SEARCH
  logic [1:0]  roots, exp_roots;

  // Multiply by alpha: x^4 folds back to x+1.
  function automatic logic [3:0] mul_a(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  // Multiply by alpha^-1 = alpha^14 (inverse of mul_a).
  function automatic logic [3:0] mul_ainv(input logic [3:0] x);
    return {x[0], x[3], x[2], x[1] ^ x[0]};
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] p;
    acc = 4'h0;
    p   = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) acc = acc ^ p;
      p = mul_a(p);
    end
    return acc;
  endfunction

  function automatic logic [3:0] gf_exp(input logic [3:0] k);
    case (k)
      4'd0:  return 4'h1;  4'd1:  return 4'h2;  4'd2:  return 4'h4;
      4'd3:  return 4'h8;  4'd4:  return 4'h3;  4'd5:  return 4'h6;
      4'd6:  return 4'hC;  4'd7:  return 4'hB;  4'd8:  return 4'h5;
      4'd9:  return 4'hA;  4'd10: return 4'h7;  4'd11: return 4'hE;
      4'd12: return 4'hF;  4'd13: return 4'hD;  4'd14: return 4'h9;
      default: return 4'h1;
    endcase
  endfunction

  function automatic logic [3:0] gf_log(input logic [3:0] x);
    case (x)
      4'h1: return 4'd0;   4'h2: return 4'd1;   4'h4: return 4'd2;
      4'h8: return 4'd3;   4'h3: return 4'd4;   4'h6: return 4'd5;
      4'hC: return 4'd6;   4'hB: return 4'd7;   4'h5: return 4'd8;
      4'hA: return 4'd9;   4'h7: return 4'd10;  4'hE: return 4'd11;
      4'hF: return 4'd12;  4'hD: return 4'd13;  4'h9: return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // Locator terms; the log table only ever sees a nonzero S1.
  logic [3:0] s1_log, s1_cube, s1_inv, sigma2;
  logic [5:0] log3;

  always_comb begin
    s1_log = (s1 != 4'h0) ? gf_log(s1) : 4'd0;
    log3   = {2'b00, s1_log} * 6'd3;
    if (log3 >= 6'd30)      log3 = log3 - 6'd30;
    else if (log3 >= 6'd15) log3 = log3 - 6'd15;
    s1_cube = (s1 != 4'h0) ? gf_exp(log3[3:0]) : 4'h0;
    s1_inv  = (s1 != 4'h0) ? gf_exp((s1_log == 4'd0) ? 4'd0 : 4'd15 - s1_log) : 4'h0;
    sigma2  = gf_mul(s3 ^ s1_cube, s1_inv);
  end

  // Chien step: sigma evaluated at alpha^-cnt.
  logic        eval_zero;
  logic [1:0]  roots_nx;
  logic [14:0] word_nx;

  always_comb begin
    eval_zero = ((4'h1 ^ t1 ^ t2) == 4'h0);
    roots_nx  = (eval_zero && roots != 2'd3) ? roots + 2'd1 : roots;
    word_nx   = eval_zero ? (word_r ^ (15'h1 << cnt)) : word_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      word_r        <= '0;
      orig_r        <= '0;
      s1            <= '0;
      s3            <= '0;
      t1            <= '0;
      t2            <= '0;
      cnt           <= '0;
      roots         <= '0;
      exp_roots     <= '0;
      cw_ready      <= 1'b1;
      msg_valid     <= 1'b0;
      busy          <= 1'b0;
      msg_data      <= '0;
      err_cnt       <= '0;
      uncorrectable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cw_valid) begin
            word_r   <= cw_data;
            orig_r   <= cw_data[14:8];
            s1       <= 4'h0;
            s3       <= 4'h0;
            cnt      <= 4'd14;
            cw_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SYND;
          end
        end

        SYND: begin
          s1 <= mul_a(s1) ^ {3'b000, word_r[cnt]};
          s3 <= mul_a(mul_a(mul_a(s3))) ^ {3'b000, word_r[cnt]};
          if (cnt == 4'd0) state <= LOCATE;
          else             cnt   <= cnt - 4'd1;
        end

        LOCATE: begin
          t1    <= s1;
          t2    <= 4'h0;
          cnt   <= 4'd0;
          roots <= 2'd0;
          state <= SEARCH;
          if (s1 == 4'h0 && s3 == 4'h0) begin
            exp_roots <= 2'd0;
            if (EARLY_EXIT) begin
              msg_data      <= word_r[14:8];
              err_cnt       <= 2'd0;
              uncorrectable <= 1'b0;
              msg_valid     <= 1'b1;
              state         <= DONE;
            end
          end else if (s1 == 4'h0) begin
            msg_data      <= orig_r;
            err_cnt       <= 2'd0;
            uncorrectable <= 1'b1;
            msg_valid     <= 1'b1;
            state         <= DONE;
          end else if (s3 == s1_cube) begin
            exp_roots <= 2'd1;
          end else begin
            exp_roots <= 2'd2;
            t2        <= sigma2;
          end
        end

        SEARCH: begin
          word_r <= word_nx;
          roots  <= roots_nx;
          t1     <= mul_ainv(t1);
          t2     <= mul_ainv(mul_ainv(t2));
          if (cnt == 4'd14) begin
            // A root count that disagrees with the syndrome class means the
            // word lies outside the correction radius; report raw bits.
            if (roots_nx == exp_roots) begin
              msg_data      <= word_nx[14:8];
              err_cnt       <= roots_nx;
              uncorrectable <= 1'b0;
            end else begin
              msg_data      <= orig_r;
              err_cnt       <= 2'd0;
              uncorrectable <= 1'b1;
            end
            msg_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          if (msg_ready) begin
            msg_valid <= 1'b0;
            cw_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bch_decode_sequencer.md
# bch_decode_sequencer

Multi-cycle decoder controller for the BCH(15,7,2) code over GF(16), primitive polynomial x^4+x+1, generator g(x) = 0x1D1. It accepts one 15-bit received word on a valid/ready handshake. It computes S1/S3 bit-serially, solves the error locator in one cycle, and runs a one-position-per-cycle Chien search. It returns the corrected 7-bit message with an error count and an uncorrectable flag. It replaces the fully combinational decode path where area matters more than latency.

## Interface
- EARLY_EXIT, 0: when 1, a word with S1 = S3 = 0 skips SEARCH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high; one clock domain only.
- cw_valid  in  1  received word available.
- cw_ready  out  1  block can accept a word (high only in IDLE).
- cw_data  in  15  received word; bit i is the coefficient of x^i; [14:8] message, [7:0] parity.
- msg_valid  out  1  result available (high only in DONE).
- msg_ready  in  1  consumer takes the result.
- msg_data  out  7  corrected message bits [14:8].
- err_cnt  out  2  number of bits corrected (0, 1 or 2).
- uncorrectable  out  1  decoding failure; msg_data holds the raw cw_data[14:8].
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SYND, LOCATE, SEARCH, DONE.
- IDLE: cw_ready=1. On cw_valid, latch cw_data into word_r, clear S1/S3, set cnt=14, go to SYND.
- SYND (15 cycles, cnt 14 down to 0), Horner scheme with MSB first:
  - S1 <= S1*alpha ^ word_r[cnt]
  - S3 <= S3*alpha^3 ^ word_r[cnt]
  - At cnt=0, go to LOCATE.
- LOCATE (1 cycle), classify the syndromes:
  - S1=0, S3=0: no error; expect 0 roots.
  - S1=0, S3≠0: uncorrectable.
  - S1≠0, S3=S1^3: single error; sigma1=S1, sigma2=0; expect 1 root.
  - Otherwise: two errors; sigma1=S1, sigma2=(S3^S1^3)*S1^-1; expect 2 roots.
  - Load t1=sigma1, t2=sigma2, i=0, roots=0.
  - Next state: SEARCH. With EARLY_EXIT=1 and no error, or with the uncorrectable case, go directly to DONE.
- SEARCH (15 cycles, i=0..14):
  - eval = 1 ^ t1 ^ t2.
  - If eval=0: flip word_r[i] and increment roots (saturating at 3).
  - Update t1 <= t1*alpha^14 and t2 <= t2*alpha^13.
  - After i=14, go to DONE.
- DONE:
  - If roots ≠ expected: uncorrectable=1, msg_data = original [14:8] (a kept copy, not the flipped word), err_cnt=0.
  - Otherwise: msg_data = word_r[14:8], err_cnt = roots.
  - Outputs hold stable while msg_valid=1 and msg_ready=0.
  - On msg_ready, go to IDLE.
- All GF(16) multiplies by constants are fixed XOR networks. S1^3 and S1^-1 use log/antilog lookup; S1=0 is never fed to the log table.

## Timing
- Reset values: state=IDLE, cw_ready=1, msg_valid=0, busy=0, msg_data=0, err_cnt=0, uncorrectable=0. All internal registers are 0.
- Take acceptance as edge 0. After edge 0 the block is in SYND; edges 1..15 process bits 14..0; edge 16 is LOCATE→SEARCH; edges 17..31 handle i=0..14.
- msg_valid rises after edge 31, i.e. 31 cycles of latency.
- With EARLY_EXIT=1 and a clean word, or an S1=0/S3≠0 word, msg_valid rises after edge 16.
- With msg_ready held at 1, msg_valid is high for exactly one cycle. cw_ready returns high in the next cycle, so the minimum period is 33 cycles per word.
- A handshake on the same edge as entering DONE is not possible; cw_ready=0 throughout SYND..DONE.
- cw_valid while busy is ignored; no data is captured.
- Asserting rst mid-operation returns to IDLE immediately (asynchronously). The partial result is discarded and msg_valid is never issued for that word.

## Test plan
- Reset, then send cw 0x0000 -> after 31 cycles msg_data=0x00, err_cnt=0, uncorrectable=0.
- Send cw 0x01D1 (message 0x01, no error), then 0x41D1 (bit 14 flipped) -> msg_data=0x01 for both; err_cnt=0 then 1.
- Send cw 0x41D3 (bits 14 and 1 flipped from 0x01D1) -> msg_data=0x01, err_cnt=2, uncorrectable=0.
- Send cw 0x0013 (errors at bits 0, 1, 4; S1=0, S3=6) -> uncorrectable=1, msg_data=0x00, err_cnt=0. With EARLY_EXIT=1, latency is 16.
- Backpressure: hold msg_ready=0 for 10 cycles in DONE -> outputs stable, cw_ready=0; a pulse on cw_valid is ignored. Release msg_ready -> one handshake, then cw_ready=1 the next cycle.
- Assert rst at edge 20 of a 0x41D3 decode -> state goes to IDLE immediately and no msg_valid appears. A following 0x01D1 decodes correctly with 31-cycle latency.
